// File: rtl/keypad_scanner_pkg.sv
// Shared definitions for the keypad scanner slice.
// Holds key-index to note/mode mappings used by the control logic, the scanner
// state type and small helpers for row drive and snapshot decoding.
package keypad_scanner_pkg;

   localparam int unsigned ROWS  = 4;
   localparam int unsigned COLS  = 4;
   localparam int unsigned KEYS  = ROWS * COLS;
   localparam int unsigned KEY_W = 4;
   localparam int unsigned POP_W = 5;

   // Key index -> note mapping (index = row*4 + col)
   localparam logic [KEY_W-1:0] KEY_DO     = 4'd0;
   localparam logic [KEY_W-1:0] KEY_RE     = 4'd1;
   localparam logic [KEY_W-1:0] KEY_MI     = 4'd2;
   localparam logic [KEY_W-1:0] KEY_FA     = 4'd4;
   localparam logic [KEY_W-1:0] KEY_SOL    = 4'd5;
   localparam logic [KEY_W-1:0] KEY_LA     = 4'd6;
   localparam logic [KEY_W-1:0] KEY_SI     = 4'd8;
   localparam logic [KEY_W-1:0] KEY_OCT_UP = 4'd3;
   localparam logic [KEY_W-1:0] KEY_OCT_DN = 4'd7;

   // Mode-select keys
   localparam logic [KEY_W-1:0] KEY_MODE_PLAY = 4'd12;
   localparam logic [KEY_W-1:0] KEY_MODE_SONG = 4'd13;
   localparam logic [KEY_W-1:0] KEY_MODE_REC  = 4'd14;
   localparam logic [KEY_W-1:0] KEY_MODE_STOP = 4'd15;

   typedef enum logic {
      ST_SCAN = 1'b0,
      ST_EVAL = 1'b1
   } scan_state_t;

   // Active-low one-cold row drive for row index r
   function automatic logic [ROWS-1:0] row_drive(input logic [1:0] r);
      return ~(4'b0001 << r);
   endfunction

   // Number of keys set in a 16-key snapshot
   function automatic logic [POP_W-1:0] key_count(input logic [KEYS-1:0] k);
      logic [POP_W-1:0] n;
      n = '0;
      for (int i = 0; i < KEYS; i++) n = n + POP_W'(k[i]);
      return n;
   endfunction

   // Index of the highest set key (snapshot assumed single-key)
   function automatic logic [KEY_W-1:0] key_index(input logic [KEYS-1:0] k);
      logic [KEY_W-1:0] idx;
      idx = '0;
      for (int i = 0; i < KEYS; i++) if (k[i]) idx = KEY_W'(i);
      return idx;
   endfunction

endpackage

// File: rtl/keypad_scanner_sync_2ff.sv
// 2-flop synchroniser for asynchronous level inputs (keypad columns, board switches).
// Ports: clk, rst (sync, active-high), d (async in), q (synchronised out).
module sync_2ff #(
   parameter int unsigned W       = 4,
   parameter logic [W-1:0] RST_VAL = '0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [W-1:0] meta;

   always_ff @(posedge clk) begin
      if (rst) begin
         meta <= RST_VAL;
         q    <= RST_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with full-snapshot debounce and single-key encoder.
// Ports: clk, rst (sync, active-high), row (active-low one-cold drive),
//        col (active-low async sense), key_code (row*4+col), key_pressed (one key held),
//        key_valid (1-cycle new-key strobe), multi_key (two or more keys held).
module keypad_scanner
   import keypad_scanner_pkg::*;
#(
   parameter int unsigned SCAN_DIV     = 100000,
   parameter int unsigned DEBOUNCE_CNT = 20
) (
   input  logic       clk,
   input  logic       rst,
   output logic [3:0] row,
   input  logic [3:0] col,
   output logic [3:0] key_code,
   output logic       key_pressed,
   output logic       key_valid,
   output logic       multi_key
);

   localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int unsigned CNT_W = $clog2(DEBOUNCE_CNT + 1);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CNT);

   scan_state_t      state;
   logic [DIV_W-1:0] div;
   logic [1:0]       ridx;
   logic [KEYS-1:0]  snap;
   logic [KEYS-1:0]  prev;
   logic [KEYS-1:0]  deb;
   logic [CNT_W-1:0] stable_cnt;
   logic [3:0]       col_s;

   // Idle columns read high, so reset the synchroniser to "no key"
   sync_2ff #(.W(4), .RST_VAL(4'hF)) u_col_sync (
      .clk (clk),
      .rst (rst),
      .d   (col),
      .q   (col_s)
   );

   // Sweep evaluation: next stable count, commit decision and candidate deb
   logic             same_c;
   logic             commit_c;
   logic [CNT_W-1:0] cnt_next_c;
   logic [KEYS-1:0]  deb_next_c;
   logic [POP_W-1:0] deb_pop_c;

   always_comb begin
      same_c     = (snap == prev);
      cnt_next_c = CNT_W'(1);
      if (same_c) cnt_next_c = (stable_cnt == CNT_MAX) ? stable_cnt : stable_cnt + CNT_W'(1);
      // Commit only on the sweep that first reaches the threshold, not while saturated
      commit_c   = (cnt_next_c == CNT_MAX) && !(same_c && (stable_cnt == CNT_MAX));
      deb_next_c = commit_c ? snap : deb;
      deb_pop_c  = key_count(deb_next_c);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_SCAN;
         div         <= '0;
         ridx        <= 2'd0;
         row         <= 4'b1110;
         snap        <= '0;
         prev        <= '0;
         deb         <= '0;
         stable_cnt  <= '0;
         key_code    <= 4'd0;
         key_pressed <= 1'b0;
         key_valid   <= 1'b0;
         multi_key   <= 1'b0;
      end else begin
         key_valid <= 1'b0;

         // Row scan runs continuously, including during the evaluation cycle
         if (div == DIV_LAST) begin
            div                     <= '0;
            snap[{ridx, 2'b00} +: 4] <= ~col_s;
            ridx                    <= ridx + 2'd1;
            row                     <= row_drive(ridx + 2'd1);
         end else begin
            div <= div + DIV_W'(1);
         end

         case (state)
            ST_SCAN: begin
               if ((div == DIV_LAST) && (ridx == 2'd3)) state <= ST_EVAL;
            end
            ST_EVAL: begin
               state      <= ST_SCAN;
               stable_cnt <= cnt_next_c;
               prev       <= snap;
               deb        <= deb_next_c;
               if (deb_pop_c == POP_W'(0)) begin
                  key_pressed <= 1'b0;
                  multi_key   <= 1'b0;
               end else if (deb_pop_c == POP_W'(1)) begin
                  key_pressed <= 1'b1;
                  multi_key   <= 1'b0;
                  key_code    <= key_index(deb_next_c);
                  key_valid   <= (deb_next_c != deb);
               end else begin
                  key_pressed <= 1'b0;
                  multi_key   <= 1'b1;
               end
            end
            default: state <= ST_SCAN;
         endcase
      end
   end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a behavioural 4x4 keypad model.
module tb_keypad_scanner;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] row;
   logic [3:0] col;
   logic [3:0] key_code;
   logic       key_pressed;
   logic       key_valid;
   logic       multi_key;

   logic [15:0] keys = '0;
   int          total  = 0;
   int          passed = 0;
   int          pulses = 0;
   logic [3:0]  last_code = 4'd0;
   bit          watch_hold = 1'b0;
   bit          hold_dropped = 1'b0;

   keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_CNT(3)) dut (
      .clk         (clk),
      .rst         (rst),
      .row         (row),
      .col         (col),
      .key_code    (key_code),
      .key_pressed (key_pressed),
      .key_valid   (key_valid),
      .multi_key   (multi_key)
   );

   always #5 clk = ~clk;

   // Keypad: a pressed key pulls its column low while its row is driven low
   always_comb begin
      col = 4'hF;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (keys[r*4 + c] && !row[r]) col[c] = 1'b0;
   end

   always @(negedge clk) begin
      if (!rst && key_valid) begin
         pulses    <= pulses + 1;
         last_code <= key_code;
      end
      if (watch_hold && !key_pressed) hold_dropped <= 1'b1;
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) passed++;
      else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   function automatic int sig_val(input int which);
      case (which)
         0:       return int'(key_pressed);
         1:       return int'(multi_key);
         default: return int'(key_code);
      endcase
   endfunction

   task automatic wait_until(input int which, input int want, input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         if (sig_val(which) == want) begin
            ok = 1'b1;
            break;
         end
         cyc(1);
      end
      if (!ok && sig_val(which) == want) ok = 1'b1;
   endtask

   initial begin
      bit ok;
      int p0;

      // 1. Reset and idle scanning
      rst = 1'b1;
      cyc(2);
      rst = 1'b0;
      chk("rst_row", 32'(row), 32'h0E);
      chk("rst_code", 32'(key_code), 32'h0);
      chk("rst_pressed", 32'(key_pressed), 32'h0);
      chk("rst_valid", 32'(key_valid), 32'h0);
      chk("rst_multi", 32'(multi_key), 32'h0);
      cyc(4);
      chk("row1", 32'(row), 32'h0D);
      cyc(4);
      chk("row2", 32'(row), 32'h0B);
      cyc(4);
      chk("row3", 32'(row), 32'h07);
      cyc(4);
      chk("row0_wrap", 32'(row), 32'h0E);
      cyc(80);
      chk("idle_pulses", 32'(pulses), 32'd0);
      chk("idle_pressed", 32'(key_pressed), 32'h0);
      chk("idle_multi", 32'(multi_key), 32'h0);

      // 2. Key 6 press and release
      p0 = pulses;
      keys = 16'h0040;
      wait_until(0, 1, 80, ok);
      chk("k6_detect", 32'(ok), 32'd1);
      cyc(2);
      chk("k6_code", 32'(key_code), 32'd6);
      chk("k6_pulse", 32'(pulses - p0), 32'd1);
      chk("k6_pulse_code", 32'(last_code), 32'd6);
      cyc(64);
      chk("k6_hold_nopulse", 32'(pulses - p0), 32'd1);
      keys = '0;
      wait_until(0, 0, 80, ok);
      chk("k6_release", 32'(ok), 32'd1);
      cyc(2);
      chk("k6_release_nopulse", 32'(pulses - p0), 32'd1);
      chk("k6_release_code", 32'(key_code), 32'd6);

      // 3. Key 9 bounces, then holds
      p0 = pulses;
      for (int i = 0; i < 11; i++) begin
         keys[9] = ~keys[9];
         cyc(3);
      end
      chk("k9_bounce_nopulse", 32'(pulses - p0), 32'd0);
      keys = 16'h0200;
      wait_until(0, 1, 96, ok);
      chk("k9_detect", 32'(ok), 32'd1);
      cyc(50);
      chk("k9_pulse", 32'(pulses - p0), 32'd1);
      chk("k9_code", 32'(last_code), 32'd9);
      keys = '0;
      wait_until(0, 0, 80, ok);
      chk("k9_release", 32'(ok), 32'd1);

      // 4. Keys 0 and 5 together, then release 5
      p0 = pulses;
      keys = 16'h0021;
      wait_until(1, 1, 80, ok);
      chk("multi_detect", 32'(ok), 32'd1);
      chk("multi_pressed", 32'(key_pressed), 32'd0);
      cyc(50);
      chk("multi_nopulse", 32'(pulses - p0), 32'd0);
      keys = 16'h0001;
      wait_until(0, 1, 80, ok);
      chk("k0_detect", 32'(ok), 32'd1);
      cyc(2);
      chk("k0_code", 32'(key_code), 32'd0);
      chk("k0_multi", 32'(multi_key), 32'd0);
      chk("k0_pulse", 32'(pulses - p0), 32'd1);
      keys = '0;
      wait_until(0, 0, 80, ok);
      chk("k0_release", 32'(ok), 32'd1);

      // 5. Key 3 switching directly to key 12
      p0 = pulses;
      keys = 16'h0008;
      wait_until(0, 1, 80, ok);
      chk("k3_detect", 32'(ok), 32'd1);
      cyc(2);
      chk("k3_code", 32'(key_code), 32'd3);
      chk("k3_pulse", 32'(pulses - p0), 32'd1);
      cyc(20);
      watch_hold = 1'b1;
      keys = 16'h1000;
      wait_until(2, 12, 80, ok);
      chk("k12_detect", 32'(ok), 32'd1);
      cyc(2);
      watch_hold = 1'b0;
      chk("k12_pulse", 32'(pulses - p0), 32'd2);
      chk("k12_pulse_code", 32'(last_code), 32'd12);
      chk("k12_no_drop", 32'(hold_dropped), 32'd0);
      keys = '0;
      wait_until(0, 0, 80, ok);
      chk("k12_release", 32'(ok), 32'd1);

      // 6. Key 6 committed, reset mid-sweep, re-detection
      p0 = pulses;
      keys = 16'h0040;
      wait_until(0, 1, 80, ok);
      chk("r6_detect", 32'(ok), 32'd1);
      cyc(7);
      rst = 1'b1;
      cyc(1);
      rst = 1'b0;
      chk("r6_rst_row", 32'(row), 32'h0E);
      chk("r6_rst_pressed", 32'(key_pressed), 32'd0);
      chk("r6_rst_code", 32'(key_code), 32'd0);
      chk("r6_rst_multi", 32'(multi_key), 32'd0);
      chk("r6_rst_valid", 32'(key_valid), 32'd0);
      wait_until(0, 1, 80, ok);
      chk("r6_redetect", 32'(ok), 32'd1);
      cyc(2);
      chk("r6_code", 32'(key_code), 32'd6);
      chk("r6_pulses", 32'(pulses - p0), 32'd2);

      cyc(10);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
